decode_cycle: RTL and testbench

//  RV32I decode stage of the 5-stage pipeline; sits downstream of fetch_cycle (IF/ID).

---
 rtl/decode_cycle_if.sv | 23 ++
 rtl/decode_cycle.sv | 91 +++++++++
 tb/tb_decode_cycle.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/decode_cycle_if.sv
// decode_cycle_if: IF/ID inputs, writeback port, flush and ID/EX outputs of the decode stage
interface decode_cycle_if;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic RegWriteW;
  logic [4:0] RdW;
  logic [31:0] ResultW;
  logic FlushE;
  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;
  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    input RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
    input RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
  );
  modport slave (
    input InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
    output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
  );
endinterface

// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage with register file and ID/EX pipeline register
module decode_cycle #(
  parameter int XLEN = 32,
  parameter bit REG_BYPASS = 1'b1
) (
  input logic clk,
  input logic rst,
  decode_cycle_if.slave bus
);
  logic [XLEN-1:0] rf [32];
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  logic isR, isI, isLw, isSw, isBeq, isJal, aluOk, regWrite, memWrite, jump, branch, aluSrc;
  logic [1:0] resultSrc;
  logic [2:0] aluControl, aluOp;
  logic [31:0] immI, immS, immB, immJ, immExt, rd1, rd2;
  logic wrEn;
  assign opcode = bus.InstrD[6:0];
  assign rd = bus.InstrD[11:7];
  assign funct3 = bus.InstrD[14:12];
  assign rs1 = bus.InstrD[19:15];
  assign rs2 = bus.InstrD[24:20];
  assign wrEn = bus.RegWriteW && bus.RdW != 5'd0;
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    else if (wrEn)
      rf[bus.RdW] <= bus.ResultW;
  // x0 is never written, so rf[0] stays zero and needs no read special case
  assign rd1 = (REG_BYPASS && wrEn && bus.RdW == rs1) ? bus.ResultW : rf[rs1];
  assign rd2 = (REG_BYPASS && wrEn && bus.RdW == rs2) ? bus.ResultW : rf[rs2];
  assign immI = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
  assign immS = {{20{bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
  assign immB = {{20{bus.InstrD[31]}}, bus.InstrD[7], bus.InstrD[30:25], bus.InstrD[11:8], 1'b0};
  assign immJ = {{12{bus.InstrD[31]}}, bus.InstrD[19:12], bus.InstrD[20], bus.InstrD[30:21], 1'b0};
  always_comb begin
    isR = opcode == 7'b0110011;
    isI = opcode == 7'b0010011;
    isLw = opcode == 7'b0000011 && funct3 == 3'b010;
    isSw = opcode == 7'b0100011 && funct3 == 3'b010;
    isBeq = opcode == 7'b1100011 && funct3 == 3'b000;
    isJal = opcode == 7'b1101111;
    aluOk = funct3 == 3'b000 || funct3 == 3'b010 || funct3 == 3'b110 || funct3 == 3'b111;
    aluOp = funct3 == 3'b000 ? ((isR && bus.InstrD[30]) ? 3'b001 : 3'b000) :
            funct3 == 3'b010 ? 3'b101 :
            funct3 == 3'b110 ? 3'b011 : 3'b010;
    regWrite = ((isR || isI) && aluOk) || isLw || isJal;
    memWrite = isSw;
    jump = isJal;
    branch = isBeq;
    aluSrc = (isI && aluOk) || isLw || isSw;
    resultSrc = isLw ? 2'b01 : isJal ? 2'b10 : 2'b00;
    aluControl = ((isR || isI) && aluOk) ? aluOp : isBeq ? 3'b001 : 3'b000;
    immExt = isSw ? immS : isBeq ? immB : isJal ? immJ : immI;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.RegWriteE <= 1'b0;
      bus.MemWriteE <= 1'b0;
      bus.JumpE <= 1'b0;
      bus.BranchE <= 1'b0;
      bus.ALUSrcE <= 1'b0;
      bus.ResultSrcE <= '0;
      bus.ALUControlE <= '0;
      bus.RD1E <= '0;
      bus.RD2E <= '0;
      bus.ImmExtE <= '0;
      bus.PCE <= '0;
      bus.PCPlus4E <= '0;
      bus.Rs1E <= '0;
      bus.Rs2E <= '0;
      bus.RdE <= '0;
    end else begin
      bus.RegWriteE <= regWrite && !bus.FlushE;
      bus.MemWriteE <= memWrite && !bus.FlushE;
      bus.JumpE <= jump && !bus.FlushE;
      bus.BranchE <= branch && !bus.FlushE;
      bus.ALUSrcE <= aluSrc;
      bus.ResultSrcE <= resultSrc;
      bus.ALUControlE <= aluControl;
      bus.RD1E <= rd1;
      bus.RD2E <= rd2;
      bus.ImmExtE <= immExt;
      bus.PCE <= bus.PCD;
      bus.PCPlus4E <= bus.PCPlus4D;
      bus.Rs1E <= rs1;
      bus.Rs2E <= rs2;
      bus.RdE <= rd;
    end
endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed checks of decode, regfile, bypass, flush and reset
module tb_decode_cycle;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  decode_cycle_if bus ();
  decode_cycle dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ctl(input string tag, input logic rw, input logic [1:0] rs, input logic mw,
                     input logic j, input logic b, input logic as, input logic [2:0] ac);
    chk({tag, ".RegWriteE"}, 32'(bus.RegWriteE), 32'(rw));
    chk({tag, ".ResultSrcE"}, 32'(bus.ResultSrcE), 32'(rs));
    chk({tag, ".MemWriteE"}, 32'(bus.MemWriteE), 32'(mw));
    chk({tag, ".JumpE"}, 32'(bus.JumpE), 32'(j));
    chk({tag, ".BranchE"}, 32'(bus.BranchE), 32'(b));
    chk({tag, ".ALUSrcE"}, 32'(bus.ALUSrcE), 32'(as));
    chk({tag, ".ALUControlE"}, 32'(bus.ALUControlE), 32'(ac));
  endtask
  initial begin
    bus.InstrD = 32'h002081B3;
    bus.PCD = 32'h40;
    bus.PCPlus4D = 32'h44;
    bus.RegWriteW = 1'b0;
    bus.RdW = 5'd0;
    bus.ResultW = 32'h0;
    bus.FlushE = 1'b0;
    step();
    step();
    ctl("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.RdE", 32'(bus.RdE), 0);
    chk("reset.PCE", bus.PCE, 0);
    chk("reset.PCPlus4E", bus.PCPlus4E, 0);
    rst = 1'b1;
    step();
    chk("release.RdE", 32'(bus.RdE), 3);
    chk("release.RegWriteE", 32'(bus.RegWriteE), 1);
    chk("release.Rs1E", 32'(bus.Rs1E), 1);
    chk("release.Rs2E", 32'(bus.Rs2E), 2);
    chk("release.PCE", bus.PCE, 32'h40);
    bus.RegWriteW = 1'b1; bus.RdW = 5'd1; bus.ResultW = 32'd5; bus.InstrD = 32'h00000013;
    step();
    bus.RdW = 5'd2; bus.ResultW = 32'd7;
    step();
    bus.RegWriteW = 1'b0; bus.InstrD = 32'h002081B3;
    step();
    chk("add.RD1E", bus.RD1E, 5);
    chk("add.RD2E", bus.RD2E, 7);
    ctl("add", 1, 0, 0, 0, 0, 0, 3'b000);
    bus.InstrD = 32'h402081B3;
    step();
    ctl("sub", 1, 0, 0, 0, 0, 0, 3'b001);
    bus.InstrD = 32'h0020E1B3;
    step();
    chk("or.ALUControlE", 32'(bus.ALUControlE), 3'b011);
    bus.InstrD = 32'h0020F1B3;
    step();
    chk("and.ALUControlE", 32'(bus.ALUControlE), 3'b010);
    bus.InstrD = 32'h0020A1B3;
    step();
    chk("slt.ALUControlE", 32'(bus.ALUControlE), 3'b101);
    bus.InstrD = 32'h002091B3;
    step();
    ctl("sll_unsupported", 0, 0, 0, 0, 0, 0, 0);
    bus.RegWriteW = 1'b1; bus.RdW = 5'd1; bus.ResultW = 32'hA5; bus.InstrD = 32'h00008093;
    step();
    chk("bypass.RD1E", bus.RD1E, 32'hA5);
    ctl("addi", 1, 0, 0, 0, 0, 1, 3'b000);
    chk("addi.ImmExtE", bus.ImmExtE, 0);
    bus.RdW = 5'd0; bus.ResultW = 32'h55; bus.InstrD = 32'h00000093;
    step();
    chk("x0_bypass.RD1E", bus.RD1E, 0);
    bus.RegWriteW = 1'b0; bus.InstrD = 32'h000001B3;
    step();
    chk("x0_read.RD1E", bus.RD1E, 0);
    chk("x0_read.RD2E", bus.RD2E, 0);
    bus.InstrD = 32'h00008093;
    step();
    chk("x1_stored.RD1E", bus.RD1E, 32'hA5);
    bus.InstrD = 32'hFE208EE3;
    step();
    chk("beq.ImmExtE", bus.ImmExtE, 32'hFFFFFFFC);
    ctl("beq", 0, 0, 0, 0, 1, 0, 3'b001);
    bus.InstrD = 32'h0020A423;
    step();
    chk("sw.ImmExtE", bus.ImmExtE, 8);
    ctl("sw", 0, 0, 1, 0, 0, 1, 3'b000);
    chk("sw.RD2E", bus.RD2E, 7);
    bus.InstrD = 32'hFF812283;
    step();
    chk("lw.ImmExtE", bus.ImmExtE, 32'hFFFFFFF8);
    ctl("lw", 1, 2'b01, 0, 0, 0, 1, 3'b000);
    chk("lw.RD1E", bus.RD1E, 7);
    chk("lw.RdE", 32'(bus.RdE), 5);
    bus.InstrD = 32'h010000EF;
    step();
    chk("jal.ImmExtE", bus.ImmExtE, 16);
    ctl("jal", 1, 2'b10, 0, 1, 0, 0, 3'b000);
    bus.FlushE = 1'b1; bus.InstrD = 32'h00500093;
    step();
    chk("flush.RegWriteE", 32'(bus.RegWriteE), 0);
    chk("flush.MemWriteE", 32'(bus.MemWriteE), 0);
    chk("flush.BranchE", 32'(bus.BranchE), 0);
    chk("flush.JumpE", 32'(bus.JumpE), 0);
    bus.InstrD = 32'h010000EF;
    step();
    chk("flush_jal.JumpE", 32'(bus.JumpE), 0);
    bus.FlushE = 1'b0; bus.InstrD = 32'h00500093;
    step();
    chk("unflush.RegWriteE", 32'(bus.RegWriteE), 1);
    chk("unflush.ImmExtE", bus.ImmExtE, 5);
    bus.InstrD = 32'hFFFFFFFF; bus.PCD = 32'h100; bus.PCPlus4D = 32'h104;
    step();
    ctl("illegal", 0, 0, 0, 0, 0, 0, 0);
    chk("illegal.PCE", bus.PCE, 32'h100);
    chk("illegal.PCPlus4E", bus.PCPlus4E, 32'h104);
    bus.InstrD = 32'h002081B3;
    step();
    #2 rst = 1'b0;
    #1;
    chk("midreset.RegWriteE", 32'(bus.RegWriteE), 0);
    chk("midreset.RD1E", bus.RD1E, 0);
    chk("midreset.PCE", bus.PCE, 0);
    #1 rst = 1'b1;
    step();
    chk("after_reset.RegWriteE", 32'(bus.RegWriteE), 1);
    chk("after_reset.RD1E", bus.RD1E, 0);
    chk("after_reset.RD2E", bus.RD2E, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
